alu_req_arbiter: RTL

Shares the registered ALU datapath (arithmetic, logic, compare and shift units) between two requesters. It arbitrates requests round-robin and decodes the 4-bit opcode into one-hot unit enables plus a 2-bit ALU_FUN. It waits out the fixed ALU latency, then returns the result and flag on a valid/ready response channel tagged with the requester ID.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/alu_req_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU request arbiter and its sub-modules.
//   - unit_e  : opcode[3:2] unit-select codes
//   - FUN_*   : opcode[1:0] function codes of the logic unit
//   - state_e : arbiter FSM state encoding
// ----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_e;

  localparam logic [1:0] FUN_AND  = 2'b00;
  localparam logic [1:0] FUN_OR   = 2'b01;
  localparam logic [1:0] FUN_NAND = 2'b10;
  localparam logic [1:0] FUN_NOR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin grant. A sole requester always wins; on a tie the
// requester that did not win last time is granted. last_grant resets to 1 so
// requester 0 wins the first tie.
// Ports:
//   clk, reset (async, active low)
//   req[1:0]   request vector, bit N = requester N
//   accept     grant was taken this cycle; commits gnt_id as last_grant
//   gnt_valid  at least one requester is asking
//   gnt_id     granted requester (meaningful when gnt_valid)
// ----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_grant;

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first); a missing branch would infer a latch.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = req[1];
    if (req == 2'b11) gnt_id = ~last_grant;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      last_grant <= 1'b1;
    else if (accept) last_grant <= gnt_id;
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// ----------------------------------------------------------------------------
// alu_req_arbiter
// Shares one registered ALU datapath between two requesters. Requests are
// granted round-robin, the opcode is decoded into a one-cycle unit enable
// plus ALU_FUN, the fixed ALU latency is waited out, and the result is
// returned on a valid/ready response channel tagged with the requester id.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
// Parameters: WIDTH (operand width), ALU_LAT (result latency, >= 1)
// Ports:
//   clk, reset (async, active low)
//   reqN_valid/ready/A/B/fun   command channel of requester N (N = 0, 1)
//   alu_A, alu_B, ALU_FUN      operands and function to the ALU units
//   arith/logic/cmp/shift_enable  one-hot unit enable, high in ISSUE only
//   alu_out, alu_flag          muxed registered ALU result and flag
//   rsp_valid/ready/id/data/flag  response channel
// Build option: define ALU_PERF_CNT_EN to add perf_cnt0/perf_cnt1, saturating
//   16-bit counts of completed response handshakes per requester.
// ----------------------------------------------------------------------------
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [3:0]       req0_fun,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [3:0]       req1_fun,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [1:0]       ALU_FUN,
  output logic             arith_enable,
  output logic             logic_enable,
  output logic             cmp_enable,
  output logic             shift_enable,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_flag
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [15:0]      perf_cnt0,
  output logic [15:0]      perf_cnt1
`endif
);

  localparam int               CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       fun_q;
  logic             id_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt_valid, gnt_id, accept;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       ({req1_valid, req0_valid}),
    .accept    (accept),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign accept = (state_q == ST_IDLE) && gnt_valid;

  // The FSM sits in IDLE while reset is held; gating ready with reset keeps
  // every output at 0 during reset instead of advertising a grant.
  assign req0_ready = reset && accept && !gnt_id;
  assign req1_ready = reset && accept &&  gnt_id;

  // Operand/function registers are only reloaded on accept, so they hold
  // through ISSUE and WAIT without extra control.
  assign alu_A   = a_q;
  assign alu_B   = b_q;
  assign ALU_FUN = fun_q[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    arith_enable = 1'b0;
    logic_enable = 1'b0;
    cmp_enable   = 1'b0;
    shift_enable = 1'b0;
    rsp_valid    = 1'b0;
    case (state_q)
      ST_IDLE:  if (gnt_valid) state_d = ST_ISSUE;
      ST_ISSUE: begin
        case (unit_e'(fun_q[3:2]))
          UNIT_ARITH: arith_enable = 1'b1;
          UNIT_LOGIC: logic_enable = 1'b1;
          UNIT_CMP:   cmp_enable   = 1'b1;
          UNIT_SHIFT: shift_enable = 1'b1;
          default:    arith_enable = 1'b0;
        endcase
        state_d = ST_WAIT;
      end
      ST_WAIT:  if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command latch, latency counter and response capture. The counter is
  // loaded in ISSUE so WAIT spans exactly ALU_LAT cycles; the last WAIT
  // cycle is the first one in which alu_out holds this op's result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      fun_q    <= '0;
      id_q     <= 1'b0;
      cnt_q    <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_flag <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= gnt_id ? req1_A   : req0_A;
        b_q   <= gnt_id ? req1_B   : req0_B;
        fun_q <= gnt_id ? req1_fun : req0_fun;
        id_q  <= gnt_id;
      end
      if (state_q == ST_ISSUE) begin
        cnt_q <= CNT_LOAD;
      end else if (state_q == ST_WAIT) begin
        if (cnt_q == '0) begin
          rsp_data <= alu_out;
          rsp_flag <= alu_flag;
          rsp_id   <= id_q;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

`ifdef ALU_PERF_CNT_EN
  logic rsp_fire;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cnt0 <= '0;
      perf_cnt1 <= '0;
    end else if (rsp_fire) begin
      if (!rsp_id && perf_cnt0 != 16'hFFFF) perf_cnt0 <= perf_cnt0 + 16'd1;
      if ( rsp_id && perf_cnt1 != 16'hFFFF) perf_cnt1 <= perf_cnt1 + 16'd1;
    end
  end
`endif

endmodule
